// File: rtl/hazard_controller_pkg.sv
// ==== hazard_controller_pkg: shared encodings for the pipeline hazard controller | Rev 1.0 ====
`default_nettype none

package hazard_controller_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] R_ZERO = '0;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = 7'b1111_000;
  localparam ctrl_t CTRL_FREEZE = 7'b0000_001;
  localparam ctrl_t CTRL_STALL  = 7'b0011_010;
  localparam ctrl_t CTRL_FLUSH  = 7'b1111_100;
  localparam ctrl_t CTRL_INIT   = 7'b0011_111;

  // r0 is hardwired zero, so a write to it can never create a dependency
  function automatic logic src_match(input logic uses, input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return uses && (src != R_ZERO) && (src == dst);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_controller_if.sv
// ==== hazard_controller_if: pipeline-side signals of the hazard controller | Rev 1.0 ====
`default_nettype none

interface hazard_controller_if
  import hazard_controller_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             id_branch_taken;
  logic             idex_memread;
  logic [REG_W-1:0] ex_rt_rd;
  logic             exmem_memread;
  logic [REG_W-1:0] exmem_rd;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             memwb_bubble;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
           idex_memread, ex_rt_rd, exmem_memread, exmem_rd, dmem_req, dmem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble,
           memwb_bubble, mem_error, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
           idex_memread, ex_rt_rd, exmem_memread, exmem_rd, dmem_req, dmem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble,
           memwb_bubble, mem_error, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_sat_counter.sv
// ==== hazard_sat_counter: enable-driven up counter that sticks at all-ones | Rev 1.0 ====
`default_nettype none

module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  output logic      [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ==== hazard_controller: stall/freeze/flush sequencing for the 5-stage pipeline | Rev 1.0 ====
`default_nettype none

module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input wire logic       clk,
  input wire logic       rst_n,
  hazard_controller_if.slave bus
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [INIT_W-1:0] init_cnt, init_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  ctrl_t             ctrl, run_ctrl;
  logic              hazard, stall_en, flush_en;
  logic [CNT_W-1:0]  stall_count, flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    // Branch-in-ID against a load in EX is covered by the plain load-use term.
    hazard = (bus.idex_memread &&
              (src_match(bus.id_uses_rs, bus.id_rs, bus.ex_rt_rd) ||
               src_match(bus.id_uses_rt, bus.id_rt, bus.ex_rt_rd))) ||
             (bus.id_is_branch && bus.exmem_memread &&
              (src_match(bus.id_uses_rs, bus.id_rs, bus.exmem_rd) ||
               src_match(bus.id_uses_rt, bus.id_rt, bus.exmem_rd)));

    if (hazard)                                    run_ctrl = CTRL_STALL;
    else if (bus.id_is_branch && bus.id_branch_taken) run_ctrl = CTRL_FLUSH;
    else                                           run_ctrl = CTRL_NORMAL;

    ctrl      = CTRL_INIT;
    state_nxt = state;
    init_nxt  = init_cnt;
    wait_nxt  = wait_cnt;

    case (state)
      ST_INIT: begin
        ctrl = CTRL_INIT;
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = ST_RUN;
        else                                      init_nxt  = init_cnt + 1'b1;
      end
      ST_RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else begin
          ctrl = run_ctrl;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          ctrl      = run_ctrl;
          state_nxt = ST_RUN;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) state_nxt = ST_ERROR;
          else                                  wait_nxt  = wait_cnt + 1'b1;
        end
      end
      ST_ERROR: ctrl = CTRL_FREEZE;
      default:  state_nxt = ST_INIT;
    endcase

    stall_en = (state != ST_INIT) && ((ctrl == CTRL_STALL) || (ctrl == CTRL_FREEZE));
    flush_en = (ctrl == CTRL_FLUSH);
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .count (stall_count)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_en),
    .count (flush_count)
  );

  assign bus.pc_write     = ctrl.pc_write;
  assign bus.ifid_write   = ctrl.ifid_write;
  assign bus.idex_write   = ctrl.idex_write;
  assign bus.exmem_write  = ctrl.exmem_write;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.idex_bubble  = ctrl.idex_bubble;
  assign bus.memwb_bubble = ctrl.memwb_bubble;
  assign bus.mem_error    = (state == ST_ERROR);
  assign bus.stall_cnt    = stall_count;
  assign bus.flush_cnt    = flush_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ==== tb_hazard_controller: directed vector table plus multi-cycle sequences | Rev 1.0 ====
`default_nettype none

module tb_hazard_controller;

  // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble}
  localparam logic [6:0] C_NORMAL = 7'b1111000;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_STALL  = 7'b0011010;
  localparam logic [6:0] C_FLUSH  = 7'b1111100;
  localparam logic [6:0] C_INIT   = 7'b0011111;

  typedef struct {
    string      name;
    logic [3:0] rs;
    logic       urs;
    logic [3:0] rt;
    logic       urt;
    logic       br;
    logic       tk;
    logic       imr;
    logic [3:0] exrd;
    logic       emr;
    logic [3:0] emrd;
    logic [6:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [15:0] exp_stall;
  logic [15:0] exp_flush;
  logic [3:0]  exp_stall_s;
  vec_t vecs [11];

  hazard_controller_if #(.CNT_W(16)) bus ();
  hazard_controller_if #(.CNT_W(4))  bus_s ();

  hazard_controller #(.INIT_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  hazard_controller #(.INIT_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(4)) u_dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  assign bus_s.id_rs           = bus.id_rs;
  assign bus_s.id_rt           = bus.id_rt;
  assign bus_s.id_uses_rs      = bus.id_uses_rs;
  assign bus_s.id_uses_rt      = bus.id_uses_rt;
  assign bus_s.id_is_branch    = bus.id_is_branch;
  assign bus_s.id_branch_taken = bus.id_branch_taken;
  assign bus_s.idex_memread    = bus.idex_memread;
  assign bus_s.ex_rt_rd        = bus.ex_rt_rd;
  assign bus_s.exmem_memread   = bus.exmem_memread;
  assign bus_s.exmem_rd        = bus.exmem_rd;
  assign bus_s.dmem_req        = bus.dmem_req;
  assign bus_s.dmem_ready      = bus.dmem_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl_now();
    return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
            bus.ifid_flush, bus.idex_bubble, bus.memwb_bubble};
  endfunction

  task automatic clear_inputs();
    bus.id_rs = 4'd0;  bus.id_rt = 4'd0;
    bus.id_uses_rs = 1'b0;  bus.id_uses_rt = 1'b0;
    bus.id_is_branch = 1'b0;  bus.id_branch_taken = 1'b0;
    bus.idex_memread = 1'b0;  bus.ex_rt_rd = 4'd0;
    bus.exmem_memread = 1'b0;  bus.exmem_rd = 4'd0;
    bus.dmem_req = 1'b0;  bus.dmem_ready = 1'b0;
  endtask

  // Compare combinational outputs mid-cycle, then advance the counter model
  task automatic check_cycle(input string name, input logic [6:0] exp, input logic exp_err);
    @(negedge clk);
    n_cmp++;
    if (ctrl_now() !== exp) begin
      n_fail++;
      $display("FAIL %s: ctrl got %b expected %b", name, ctrl_now(), exp);
    end
    n_cmp++;
    if (bus.mem_error !== exp_err) begin
      n_fail++;
      $display("FAIL %s: mem_error got %b expected %b", name, bus.mem_error, exp_err);
    end
    if (exp == C_STALL || exp == C_FREEZE) begin
      if (exp_stall != 16'hFFFF) exp_stall++;
      if (exp_stall_s != 4'hF) exp_stall_s++;
    end
    if (exp == C_FLUSH && exp_flush != 16'hFFFF) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name);
    n_cmp++;
    if (bus.stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL %s: stall_cnt got %0d expected %0d", name, bus.stall_cnt, exp_stall);
    end
    n_cmp++;
    if (bus.flush_cnt !== exp_flush) begin
      n_fail++;
      $display("FAIL %s: flush_cnt got %0d expected %0d", name, bus.flush_cnt, exp_flush);
    end
    n_cmp++;
    if (bus_s.stall_cnt !== exp_stall_s) begin
      n_fail++;
      $display("FAIL %s: small stall_cnt got %0d expected %0d", name, bus_s.stall_cnt, exp_stall_s);
    end
  endtask

  task automatic init_sequence(input string name);
    for (int i = 0; i < 4; i++) check_cycle($sformatf("%s_init%0d", name, i), C_INIT, 1'b0);
    check_cycle({name, "_run"}, C_NORMAL, 1'b0);
  endtask

  task automatic load_use_setup();
    bus.id_rs = 4'd5;  bus.id_uses_rs = 1'b1;
    bus.idex_memread = 1'b1;  bus.ex_rt_rd = 4'd5;
  endtask

  initial begin
    vecs[0]  = '{"lu_rs",        4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, C_STALL};
    vecs[1]  = '{"lu_r0",        4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, C_NORMAL};
    vecs[2]  = '{"lu_unused_rs", 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, C_NORMAL};
    vecs[3]  = '{"lu_rt",        4'd2, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, C_STALL};
    vecs[4]  = '{"alu_in_ex",    4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, C_NORMAL};
    vecs[5]  = '{"br_mem_load",  4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, C_STALL};
    vecs[6]  = '{"nobr_mem_ld",  4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, C_NORMAL};
    vecs[7]  = '{"br_taken",     4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, C_FLUSH};
    vecs[8]  = '{"br_taken_lu",  4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, C_STALL};
    vecs[9]  = '{"br_not_taken", 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, C_NORMAL};
    vecs[10] = '{"br_mem_alu",   4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd4, C_FLUSH};

    exp_stall = '0;  exp_flush = '0;  exp_stall_s = '0;
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (ctrl_now() !== C_INIT) begin
      n_fail++;
      $display("FAIL in_reset: ctrl got %b expected %b", ctrl_now(), C_INIT);
    end
    rst_n = 1'b1;

    init_sequence("por");
    check_cnt("after_init");

    foreach (vecs[k]) begin
      bus.id_rs = vecs[k].rs;           bus.id_uses_rs = vecs[k].urs;
      bus.id_rt = vecs[k].rt;           bus.id_uses_rt = vecs[k].urt;
      bus.id_is_branch = vecs[k].br;    bus.id_branch_taken = vecs[k].tk;
      bus.idex_memread = vecs[k].imr;   bus.ex_rt_rd = vecs[k].exrd;
      bus.exmem_memread = vecs[k].emr;  bus.exmem_rd = vecs[k].emrd;
      check_cycle(vecs[k].name, vecs[k].exp, 1'b0);
    end
    clear_inputs();
    check_cnt("after_table");

    // Branch waiting on a load: two stalls as the load moves EX -> MEM, then resolve taken
    bus.id_is_branch = 1'b1;  bus.id_rt = 4'd3;  bus.id_uses_rt = 1'b1;
    bus.idex_memread = 1'b1;  bus.ex_rt_rd = 4'd3;
    check_cycle("br_load_1", C_STALL, 1'b0);
    bus.idex_memread = 1'b0;  bus.ex_rt_rd = 4'd0;
    bus.exmem_memread = 1'b1; bus.exmem_rd = 4'd3;
    check_cycle("br_load_2", C_STALL, 1'b0);
    bus.exmem_memread = 1'b0; bus.exmem_rd = 4'd0;  bus.id_branch_taken = 1'b1;
    check_cycle("br_load_3", C_FLUSH, 1'b0);
    clear_inputs();
    check_cnt("after_branch_load");

    bus.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) check_cycle($sformatf("mem_wait%0d", i), C_FREEZE, 1'b0);
    bus.dmem_ready = 1'b1;
    check_cycle("mem_ready", C_NORMAL, 1'b0);
    clear_inputs();
    check_cycle("mem_after", C_NORMAL, 1'b0);
    check_cnt("after_mem_wait");

    // Data returns while a load-use hazard is present: stall rules still apply
    bus.dmem_req = 1'b1;
    check_cycle("mem_wait_hz", C_FREEZE, 1'b0);
    bus.dmem_ready = 1'b1;
    load_use_setup();
    check_cycle("mem_ready_hz", C_STALL, 1'b0);
    clear_inputs();
    check_cycle("mem_hz_after", C_NORMAL, 1'b0);

    bus.dmem_req = 1'b1;
    for (int i = 0; i < 17; i++) check_cycle($sformatf("timeout%0d", i), C_FREEZE, 1'b0);
    check_cycle("error_entry", C_FREEZE, 1'b1);
    bus.dmem_ready = 1'b1;
    check_cycle("error_ready", C_FREEZE, 1'b1);
    bus.dmem_req = 1'b0;
    check_cycle("error_sticky", C_FREEZE, 1'b1);
    check_cnt("in_error");

    // Asynchronous reset lands mid-cycle and must take effect before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    exp_stall = '0;  exp_flush = '0;  exp_stall_s = '0;
    n_cmp++;
    if (bus.mem_error !== 1'b0 || ctrl_now() !== C_INIT) begin
      n_fail++;
      $display("FAIL async_reset: mem_error %b ctrl %b expected 0 %b", bus.mem_error, ctrl_now(), C_INIT);
    end
    check_cnt("async_reset");
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_sequence("rerun");

    load_use_setup();
    for (int i = 0; i < 20; i++) check_cycle($sformatf("sat%0d", i), C_STALL, 1'b0);
    clear_inputs();
    check_cnt("saturation");
    n_cmp++;
    if (bus_s.stall_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_hold: small stall_cnt got %0d expected 15", bus_s.stall_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
